dac8728_ch_sched: RTL and testbench

//  Upstream feeder for the DAC8728 write controller. Holds 8 signed 16-bit channel setpoints.

---
 rtl/dac8728_pkg.sv | 21 ++
 rtl/dac8728_ch_sched_if.sv | 26 ++
 rtl/dac8728_next_ch.sv | 30 +++
 rtl/dac8728_ch_sched.sv | 137 +++++++++++++
 tb/tb_dac8728_ch_sched.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac8728_pkg.sv
// rtl/dac8728_pkg.sv - shared widths, one-hot scheduler states and saturation helper
package dac8728_pkg;
  localparam int NUM_CH_MAX = 8;
  localparam int CH_W       = 3;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 16;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_PRESENT = 4'b0010;
  localparam logic [3:0] ST_WAIT    = 4'b0100;
  localparam logic [3:0] ST_ADVANCE = 4'b1000;

  function automatic logic [DATA_W-1:0] sat16(input logic signed [DATA_W:0] v);
    if (v > 17'sd32767)
      return 16'h7FFF;
    else if (v < -17'sd32768)
      return 16'h8000;
    else
      return v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/dac8728_ch_sched_if.sv
// rtl/dac8728_ch_sched_if.sv - host/controller bundle of the channel scheduler
interface dac8728_ch_sched_if;
  import dac8728_pkg::*;

  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [DATA_W-1:0]     wr_data;
  logic                  commit;
  logic [NUM_CH_MAX-1:0] ch_mask;
  logic                  done_dac;
  logic [ADDR_W-1:0]     add_in;
  logic [DATA_W-1:0]     data_in;
  logic                  frame_done;
  logic                  commit_ack;
  logic                  err_timeout;

  modport master (
    output wr_en, wr_ch, wr_data, commit, ch_mask, done_dac,
    input  add_in, data_in, frame_done, commit_ack, err_timeout
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, commit, ch_mask, done_dac,
    output add_in, data_in, frame_done, commit_ack, err_timeout
  );
endinterface

// File: rtl/dac8728_next_ch.sv
// rtl/dac8728_next_ch.sv - next enabled channel above cur_ch, wrapping to the lowest enabled
module dac8728_next_ch
  import dac8728_pkg::*;
(
  input  logic [NUM_CH_MAX-1:0] mask,
  input  logic [CH_W-1:0]       cur_ch,
  output logic [CH_W-1:0]       next_ch,
  output logic                  wrap
);
  logic            found;
  logic [CH_W-1:0] above;
  logic [CH_W-1:0] lowest;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    found  = 1'b0;
    above  = cur_ch;
    lowest = cur_ch;
    for (int i = NUM_CH_MAX - 1; i >= 0; i--) begin
      if (mask[i])
        lowest = CH_W'(i);
      if (mask[i] && (i > int'(cur_ch))) begin
        found = 1'b1;
        above = CH_W'(i);
      end
    end
    wrap    = !found && (mask != '0);
    next_ch = found ? above : lowest;
  end
endmodule

// File: rtl/dac8728_ch_sched.sv
// rtl/dac8728_ch_sched.sv - round-robin setpoint feeder with shadow/active banks
// Optional slew limiting of presented values when DAC_SLEW_LIMIT_EN is defined.
module dac8728_ch_sched
  import dac8728_pkg::*;
#(
  parameter int                NUM_CH       = 8,
  parameter logic [ADDR_W-1:0] CH_ADDR_BASE = 5'd8,
  parameter logic [31:0]       TIMEOUT      = 32'd4096,
  parameter logic [DATA_W-1:0] MAX_STEP     = 16'd256
) (
  input logic              clk,
  input logic              rst,
  dac8728_ch_sched_if.slave bus
);
  localparam logic [NUM_CH_MAX-1:0] CH_VALID = NUM_CH_MAX'((1 << NUM_CH) - 1);

  logic [3:0]            state;
  logic [CH_W-1:0]       cur_ch;
  logic [CH_W-1:0]       nxt_ch;
  logic                  wrap;
  logic                  commit_pend;
  logic [31:0]           cnt;
  logic [NUM_CH_MAX-1:0] mask_eff;
  logic [DATA_W-1:0]     present_val;
  logic [DATA_W-1:0]     shadow [NUM_CH_MAX];
  logic [DATA_W-1:0]     active [NUM_CH_MAX];

  assign mask_eff = bus.ch_mask & CH_VALID;

  dac8728_next_ch u_next_ch (
    .mask    (mask_eff),
    .cur_ch  (cur_ch),
    .next_ch (nxt_ch),
    .wrap    (wrap)
  );

`ifdef DAC_SLEW_LIMIT_EN
  logic [DATA_W-1:0]       last_sent [NUM_CH_MAX];
  logic signed [DATA_W:0]  diff;
  logic signed [DATA_W:0]  step;
  logic signed [DATA_W:0]  max_s;

  always_comb begin
    max_s = $signed({1'b0, MAX_STEP});
    diff  = $signed({active[cur_ch][DATA_W-1], active[cur_ch]})
          - $signed({last_sent[cur_ch][DATA_W-1], last_sent[cur_ch]});
    step  = diff;
    if (diff > max_s)
      step = max_s;
    else if (diff < -max_s)
      step = -max_s;
    present_val = sat16($signed({last_sent[cur_ch][DATA_W-1], last_sent[cur_ch]}) + step);
  end

  // The controller has latched data_in by the time it pulses done_dac.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH_MAX; i++)
        last_sent[i] <= '0;
    end else if (state == ST_WAIT && bus.done_dac) begin
      last_sent[cur_ch] <= bus.data_in;
    end
  end
`else
  logic unused_max_step;
  assign unused_max_step = ^MAX_STEP;
  assign present_val     = active[cur_ch];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cur_ch          <= '0;
      cnt             <= '0;
      commit_pend     <= 1'b0;
      bus.add_in      <= CH_ADDR_BASE;
      bus.data_in     <= '0;
      bus.frame_done  <= 1'b0;
      bus.commit_ack  <= 1'b0;
      bus.err_timeout <= 1'b0;
      for (int i = 0; i < NUM_CH_MAX; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      bus.frame_done <= 1'b0;
      bus.commit_ack <= 1'b0;
      if (bus.wr_en && (int'(bus.wr_ch) < NUM_CH))
        shadow[bus.wr_ch] <= bus.wr_data;
      if (bus.commit)
        commit_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (mask_eff != '0) begin
            state <= ST_PRESENT;
            if (!mask_eff[cur_ch])
              cur_ch <= nxt_ch;
          end
        end
        ST_PRESENT: begin
          bus.add_in  <= CH_ADDR_BASE + ADDR_W'(cur_ch);
          bus.data_in <= present_val;
          cnt         <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.done_dac)
            state <= ST_ADVANCE;
          else if (cnt >= TIMEOUT - 32'd1)
            bus.err_timeout <= 1'b1;
          else
            cnt <= cnt + 32'd1;
        end
        ST_ADVANCE: begin
          if (mask_eff == '0) begin
            state <= ST_IDLE;
          end else begin
            cur_ch <= nxt_ch;
            state  <= ST_PRESENT;
            if (wrap) begin
              bus.frame_done <= 1'b1;
              // A commit arriving with the copy stays pending for the next wrap.
              if (commit_pend) begin
                for (int i = 0; i < NUM_CH_MAX; i++)
                  active[i] <= shadow[i];
                bus.commit_ack <= 1'b1;
                commit_pend    <= bus.commit;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac8728_ch_sched.sv
// tb/tb_dac8728_ch_sched.sv - randomized self-checking bench with a frame-level reference model
// Adds the slew sequence check when DAC_SLEW_LIMIT_EN is defined.
module tb_dac8728_ch_sched;
  import dac8728_pkg::*;

  localparam int          NUM_CH = 8;
  localparam logic [4:0]  BASE   = 5'd8;
  localparam logic [31:0] TMO    = 32'd100;
  localparam int          MSTEP  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac8728_ch_sched_if bus ();

  dac8728_ch_sched #(
    .NUM_CH       (NUM_CH),
    .CH_ADDR_BASE (BASE),
    .TIMEOUT      (TMO),
    .MAX_STEP     (16'(MSTEP))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int m_shadow [8];
  int m_active [8];
  int m_last   [8];
  int seen     [8];
  int m_ch;
  bit m_pend;
  int n_checks = 0;
  int n_fail   = 0;

  bit          g_we;
  int          g_ch;
  logic [15:0] g_data;
  bit          g_cm;

  function automatic int tb_next(input int cur, input logic [7:0] m, output bit w);
    for (int i = cur + 1; i < 8; i++)
      if (m[i]) begin w = 1'b0; return i; end
    w = 1'b1;
    for (int i = 0; i < 8; i++)
      if (m[i]) return i;
    return cur;
  endfunction

  function automatic int exp_data(input int ch);
`ifdef DAC_SLEW_LIMIT_EN
    int d;
    int v;
    d = m_active[ch] - m_last[ch];
    if (d > MSTEP) d = MSTEP;
    if (d < -MSTEP) d = -MSTEP;
    v = m_last[ch] + d;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
`else
    return m_active[ch];
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 0; m_active[i] = 0; m_last[i] = 0; seen[i] = 0;
    end
    m_ch   = 0;
    m_pend = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
    bus.commit = 1'b0; bus.done_dac = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    bus.ch_mask = '0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start(input logic [7:0] mask);
    bit w;
    bus.ch_mask = mask;
    m_ch = mask[0] ? 0 : tb_next(0, mask, w);
    repeat (2) @(negedge clk);
  endtask

  task automatic host_cycle(input bit we, input int ch, input logic [15:0] data, input bit cm);
    bus.wr_en = we; bus.wr_ch = 3'(ch); bus.wr_data = data; bus.commit = cm;
    @(posedge clk);
    if (we) m_shadow[ch] = int'($signed(data));
    if (cm) m_pend = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

  // One update: check the presented pair, pulse done_dac, check the advance outcome.
  task automatic serve(input int n, input bit rnd, input bit op_at_wrap);
    int          e, nx, idle, ach;
    bit          w, exp_ack, awe, acm;
    logic [15:0] adata;
    for (int it = 0; it < n; it++) begin
      e = exp_data(m_ch);
      n_checks++;
      if (bus.add_in !== 5'(BASE + 5'(m_ch)) || bus.data_in !== 16'(e)) begin
        n_fail++;
        $display("FAIL present: add_in=%0d data_in=%h required add_in=%0d data_in=%h",
                 bus.add_in, bus.data_in, BASE + 5'(m_ch), 16'(e));
      end
      seen[m_ch] = int'($signed(bus.data_in));
      idle = rnd ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < idle; k++) begin
        if ($urandom_range(0, 7) == 0) bus.ch_mask = 8'($urandom_range(1, 255));
        host_cycle(1'($urandom), int'($urandom_range(0, 7)), 16'($urandom),
                   $urandom_range(0, 3) == 0);
        n_checks++;
        if (bus.add_in !== 5'(BASE + 5'(m_ch)) || bus.data_in !== 16'(e)) begin
          n_fail++;
          $display("FAIL hold: add_in=%0d data_in=%h required add_in=%0d data_in=%h",
                   bus.add_in, bus.data_in, BASE + 5'(m_ch), 16'(e));
        end
      end
      bus.done_dac = 1'b1;
      @(posedge clk);
      m_last[m_ch] = e;
      @(negedge clk);
      bus.done_dac = 1'b0;
      nx = tb_next(m_ch, bus.ch_mask, w);
      awe = 1'b0; ach = 0; adata = '0; acm = 1'b0;
      if (rnd) begin
        awe = 1'($urandom); ach = int'($urandom_range(0, 7)); adata = 16'($urandom);
        acm = $urandom_range(0, 2) == 0;
        bus.done_dac = 1'($urandom);
      end else if (op_at_wrap && w) begin
        awe = g_we; ach = g_ch; adata = g_data; acm = g_cm;
      end
      bus.wr_en = awe; bus.wr_ch = 3'(ach); bus.wr_data = adata; bus.commit = acm;
      @(posedge clk);
      exp_ack = w && m_pend;
      if (exp_ack) begin
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
        m_pend = acm;
      end else if (acm) begin
        m_pend = 1'b1;
      end
      if (awe) m_shadow[ach] = int'($signed(adata));
      m_ch = nx;
      @(negedge clk);
      clear_inputs();
      n_checks++;
      if (bus.frame_done !== w || bus.commit_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL advance: frame_done=%b commit_ack=%b required frame_done=%b commit_ack=%b",
                 bus.frame_done, bus.commit_ack, w, exp_ack);
      end
      if (rnd) bus.done_dac = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      bus.done_dac = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.add_in !== 5'd8 || bus.data_in !== 16'h0 || bus.frame_done !== 1'b0 ||
        bus.commit_ack !== 1'b0 || bus.err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: add_in=%0d data_in=%h fd=%b ack=%b err=%b required 8 0000 0 0 0",
               bus.add_in, bus.data_in, bus.frame_done, bus.commit_ack, bus.err_timeout);
    end
    do_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.add_in !== 5'd8 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_mask0: add_in=%0d frame_done=%b required 8 0", bus.add_in, bus.frame_done);
    end
  endtask

  task automatic test_full_walk();
    do_reset();
    start(8'hFF);
    serve(8, 1'b0, 1'b0);
    n_checks++;
    if (bus.add_in !== 5'd8) begin
      n_fail++;
      $display("FAIL walk_wrap: add_in=%0d required 8", bus.add_in);
    end
  endtask

  task automatic test_commit_midframe();
    serve(1, 1'b0, 1'b0);
    host_cycle(1'b1, 3, 16'h1234, 1'b0);
    host_cycle(1'b0, 0, 16'h0, 1'b1);
    serve(7, 1'b0, 1'b0);
    n_checks++;
    if (seen[3] !== 0) begin
      n_fail++;
      $display("FAIL commit_midframe_old: ch3=%h required 0000", 16'(seen[3]));
    end
    serve(8, 1'b0, 1'b0);
    n_checks++;
    if (seen[3] !== int'($signed(16'h1234))) begin
      n_fail++;
      $display("FAIL commit_midframe_new: ch3=%h required 1234", 16'(seen[3]));
    end
  endtask

  task automatic test_sparse_mask();
    do_reset();
    start(8'b0010_0100);
    n_checks++;
    if (bus.add_in !== 5'd10) begin
      n_fail++;
      $display("FAIL sparse_first: add_in=%0d required 10", bus.add_in);
    end
    serve(6, 1'b0, 1'b0);
  endtask

  task automatic test_same_cycle_copy();
    do_reset();
    start(8'h81);
    host_cycle(1'b1, 7, 16'h1111, 1'b1);
    serve(1, 1'b0, 1'b0);
    g_we = 1'b1; g_ch = 7; g_data = 16'h2222; g_cm = 1'b0;
    serve(1, 1'b0, 1'b1);
    serve(2, 1'b0, 1'b0);
    serve(2, 1'b0, 1'b0);
    n_checks++;
    if (seen[7] !== 32'h1111) begin
      n_fail++;
      $display("FAIL same_cycle_old: ch7=%h required 1111", 16'(seen[7]));
    end
    host_cycle(1'b0, 0, 16'h0, 1'b1);
    serve(2, 1'b0, 1'b0);
    serve(2, 1'b0, 1'b0);
    n_checks++;
    if (seen[7] !== 32'h2222) begin
      n_fail++;
      $display("FAIL same_cycle_new: ch7=%h required 2222", 16'(seen[7]));
    end
    host_cycle(1'b0, 0, 16'h0, 1'b1);
    g_we = 1'b0; g_cm = 1'b1;
    serve(4, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    do_reset();
    start(8'hFF);
    repeat (int'(TMO) - 4) @(negedge clk);
    n_checks++;
    if (bus.err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: err_timeout=%b required 0", bus.err_timeout);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (bus.err_timeout !== 1'b1 || bus.add_in !== 5'd8 || bus.data_in !== 16'h0) begin
      n_fail++;
      $display("FAIL timeout_set: err=%b add_in=%0d data_in=%h required 1 8 0000",
               bus.err_timeout, bus.add_in, bus.data_in);
    end
    serve(3, 1'b0, 1'b0);
    n_checks++;
    if (bus.err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: err_timeout=%b required 1", bus.err_timeout);
    end
    do_reset();
    n_checks++;
    if (bus.err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err_timeout=%b required 0", bus.err_timeout);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 12; i++)
      host_cycle(1'b1, int'($urandom_range(0, 7)), 16'($urandom), i == 11);
    start(8'($urandom_range(1, 255)));
    serve(80, 1'b1, 1'b0);
    n_checks++;
    if (bus.err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL random_err: err_timeout=%b required 0", bus.err_timeout);
    end
  endtask

`ifdef DAC_SLEW_LIMIT_EN
  task automatic test_slew();
    do_reset();
    start(8'h01);
    host_cycle(1'b1, 0, 16'h0400, 1'b1);
    serve(1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (bus.data_in !== 16'(256 * (i > 4 ? 4 : i))) begin
        n_fail++;
        $display("FAIL slew_step%0d: data_in=%h required %h", i, bus.data_in,
                 16'(256 * (i > 4 ? 4 : i)));
      end
      serve(1, 1'b0, 1'b0);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    bus.ch_mask = '0;
    g_we = 1'b0; g_ch = 0; g_data = '0; g_cm = 1'b0;
    model_reset();
    test_reset();
    test_full_walk();
    test_commit_midframe();
    test_sparse_mask();
    test_same_cycle_copy();
    test_timeout();
    test_random();
`ifdef DAC_SLEW_LIMIT_EN
    test_slew();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
